// File: rtl/axil_cmd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axil_cmd_pkg
//  Purpose  : Shared encodings for the AXI4-Lite command master: command
//             opcodes, FSM state codes, AXI response codes and the word
//             offsets of the sha256_axi register map.
//  Revision : 1.0  initial release
// ============================================================================
package axil_cmd_pkg;

    // Command opcodes carried on cmd_op
    localparam logic [1:0] OP_WRITE    = 2'd0;
    localparam logic [1:0] OP_READ     = 2'd1;
    localparam logic [1:0] OP_WAIT_IRQ = 2'd2;
    localparam logic [1:0] OP_RSVD     = 2'd3;

    // Master FSM state codes
    localparam int         STATE_W     = 3;
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WR_AW_W  = 3'd1;
    localparam logic [2:0] ST_WR_B     = 3'd2;
    localparam logic [2:0] ST_RD_AR    = 3'd3;
    localparam logic [2:0] ST_RD_R     = 3'd4;
    localparam logic [2:0] ST_WAIT_IRQ = 3'd5;
    localparam logic [2:0] ST_RSP      = 3'd6;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // sha256_axi register map, in 32-bit word addresses
    localparam int SHA_CTRL_WORD = 'h00;
    localparam int SHA_HASH_WORD = 'h08;
    localparam int SHA_MSG_WORD  = 'h10;

endpackage
`default_nettype wire

// File: rtl/axil_phase_timer.sv
`default_nettype none
// ============================================================================
//  Module   : axil_phase_timer
//  Purpose  : Counts cycles spent in one handshake phase. i_load marks the
//             first cycle of a phase, i_enable is high for every cycle of a
//             timed phase, o_expire flags the TIMEOUT_CYCLES-th cycle.
//  Revision : 1.0  initial release
// ============================================================================
module axil_phase_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_enable,
    output logic o_expire
);

    localparam int             c_cw   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_cw-1:0] c_last = c_cw'(TIMEOUT_CYCLES - 1);

    logic [c_cw-1:0] r_cnt;
    logic [c_cw-1:0] w_cnt_eff;

    // The load cycle counts as cycle zero of the new phase
    assign w_cnt_eff = i_load ? '0 : r_cnt;
    assign o_expire  = i_enable && (w_cnt_eff == c_last);

    // Cycle counter, saturates once the phase has expired
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_enable && !o_expire) begin
            r_cnt <= w_cnt_eff + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/axil_cmd_master.sv
`default_nettype none
// ============================================================================
//  Module   : axil_cmd_master
//  Purpose  : AXI4-Lite master engine. Executes WRITE / READ / WAIT_IRQ
//             commands from a valid/ready command port and returns exactly
//             one response per command. One transaction in flight at most.
//             Optional feature macro: AXIL_MST_TIMEOUT_EN enables a
//             per-phase timeout that aborts a stalled handshake.
//  Revision : 1.0  initial release
// ============================================================================
module axil_cmd_master
    import axil_cmd_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int IRQ_WIDTH      = 1,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                                        aclk,
    input  logic                                        areset,
    input  logic                                        cmd_valid,
    output logic                                        cmd_ready,
    input  logic [1:0]                                  cmd_op,
    input  logic [ADDR_WIDTH-$clog2(DATA_WIDTH/8)-1:0]  cmd_addr,
    input  logic [DATA_WIDTH-1:0]                       cmd_data,
    output logic                                        rsp_valid,
    input  logic                                        rsp_ready,
    output logic [DATA_WIDTH-1:0]                       rsp_data,
    output logic [1:0]                                  rsp_resp,
    output logic                                        rsp_err,
    input  logic [IRQ_WIDTH-1:0]                        irq,
    output logic [ADDR_WIDTH-1:0]                       M_AXI_AWADDR,
    output logic [2:0]                                  M_AXI_AWPROT,
    output logic                                        M_AXI_AWVALID,
    input  logic                                        M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]                       M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0]                     M_AXI_WSTRB,
    output logic                                        M_AXI_WVALID,
    input  logic                                        M_AXI_WREADY,
    input  logic [1:0]                                  M_AXI_BRESP,
    input  logic                                        M_AXI_BVALID,
    output logic                                        M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]                       M_AXI_ARADDR,
    output logic [2:0]                                  M_AXI_ARPROT,
    output logic                                        M_AXI_ARVALID,
    input  logic                                        M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]                       M_AXI_RDATA,
    input  logic [1:0]                                  M_AXI_RRESP,
    input  logic                                        M_AXI_RVALID,
    output logic                                        M_AXI_RREADY
);

    localparam int c_al = $clog2(DATA_WIDTH/8);

    logic [STATE_W-1:0]    r_state;
    logic [IRQ_WIDTH-1:0]  r_mask;
    logic                  r_cmd_ready;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic [1:0]            r_rsp_resp;
    logic                  r_rsp_err;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic                  r_awvalid;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_wvalid;
    logic                  r_bready;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic                  r_arvalid;
    logic                  r_rready;

    logic w_aw_done;
    logic w_w_done;
    logic w_irq_hit;
    logic w_phase_done;
    logic w_expire;
    logic w_abort;

    // A channel is done once its valid has dropped or it handshakes now
    assign w_aw_done = !r_awvalid || M_AXI_AWREADY;
    assign w_w_done  = !r_wvalid  || M_AXI_WREADY;
    assign w_irq_hit = |(irq & r_mask);

    // Phase completion; a handshake in the expiry cycle still wins
    always_comb begin
        w_phase_done = 1'b0;
        case (r_state)
            ST_WR_AW_W:  w_phase_done = w_aw_done && w_w_done;
            ST_WR_B:     w_phase_done = M_AXI_BVALID;
            ST_RD_AR:    w_phase_done = M_AXI_ARREADY;
            ST_RD_R:     w_phase_done = M_AXI_RVALID;
            ST_WAIT_IRQ: w_phase_done = (r_mask == '0) || w_irq_hit;
            default:     w_phase_done = 1'b0;
        endcase
    end

`ifdef AXIL_MST_TIMEOUT_EN
    logic [STATE_W-1:0] r_prev_state;
    logic               w_tmr_en;
    logic               w_tmr_load;

    assign w_tmr_en   = (r_state == ST_WR_AW_W) || (r_state == ST_WR_B) ||
                        (r_state == ST_RD_AR)   || (r_state == ST_RD_R) ||
                        (r_state == ST_WAIT_IRQ);
    // Any state change marks the first cycle of a new phase
    assign w_tmr_load = (r_state != r_prev_state);

    // Previous state, used to detect phase entry
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_prev_state <= ST_IDLE;
        end else begin
            r_prev_state <= r_state;
        end
    end

    axil_phase_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_phase_timer (
        .clk      (aclk),
        .rst      (areset),
        .i_load   (w_tmr_load),
        .i_enable (w_tmr_en),
        .o_expire (w_expire)
    );
`else
    assign w_expire = 1'b0;
`endif

    assign w_abort = w_expire && !w_phase_done;

    // Command sequencer FSM with registered bus and response outputs
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state     <= ST_IDLE;
            r_mask      <= '0;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_resp  <= RESP_OKAY;
            r_rsp_err   <= 1'b0;
            r_awaddr    <= '0;
            r_awvalid   <= 1'b0;
            r_wdata     <= '0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_araddr    <= '0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
        end else if (w_abort) begin
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_resp  <= RESP_SLVERR;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RSP;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_cmd_ready <= 1'b0;
                        case (cmd_op)
                            OP_WRITE: begin
                                r_awaddr  <= {cmd_addr, {c_al{1'b0}}};
                                r_wdata   <= cmd_data;
                                r_awvalid <= 1'b1;
                                r_wvalid  <= 1'b1;
                                r_state   <= ST_WR_AW_W;
                            end
                            OP_READ: begin
                                r_araddr  <= {cmd_addr, {c_al{1'b0}}};
                                r_arvalid <= 1'b1;
                                r_state   <= ST_RD_AR;
                            end
                            OP_WAIT_IRQ: begin
                                r_mask  <= cmd_data[IRQ_WIDTH-1:0];
                                r_state <= ST_WAIT_IRQ;
                            end
                            default: begin
                                r_rsp_data  <= '0;
                                r_rsp_resp  <= RESP_OKAY;
                                r_rsp_err   <= 1'b1;
                                r_rsp_valid <= 1'b1;
                                r_state     <= ST_RSP;
                            end
                        endcase
                    end
                end
                ST_WR_AW_W: begin
                    if (r_awvalid && M_AXI_AWREADY) r_awvalid <= 1'b0;
                    if (r_wvalid && M_AXI_WREADY)   r_wvalid  <= 1'b0;
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= ST_WR_B;
                    end
                end
                ST_WR_B: begin
                    if (M_AXI_BVALID) begin
                        r_bready    <= 1'b0;
                        r_rsp_data  <= '0;
                        r_rsp_resp  <= M_AXI_BRESP;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RSP;
                    end
                end
                ST_RD_AR: begin
                    if (M_AXI_ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= ST_RD_R;
                    end
                end
                ST_RD_R: begin
                    if (M_AXI_RVALID) begin
                        r_rready    <= 1'b0;
                        r_rsp_data  <= M_AXI_RDATA;
                        r_rsp_resp  <= M_AXI_RRESP;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RSP;
                    end
                end
                ST_WAIT_IRQ: begin
                    if (r_mask == '0) begin
                        r_rsp_data  <= '0;
                        r_rsp_resp  <= RESP_OKAY;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RSP;
                    end else if (w_irq_hit) begin
                        r_rsp_data  <= DATA_WIDTH'(irq);
                        r_rsp_resp  <= RESP_OKAY;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_cmd_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready     = r_cmd_ready;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_data      = r_rsp_data;
    assign rsp_resp      = r_rsp_resp;
    assign rsp_err       = r_rsp_err;
    assign M_AXI_AWADDR  = r_awaddr;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_BREADY  = r_bready;
    assign M_AXI_ARADDR  = r_araddr;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = r_arvalid;
    assign M_AXI_RREADY  = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_axil_cmd_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axil_cmd_master
//  Purpose  : Self-checking bench for axil_cmd_master with a small AXI4-Lite
//             slave model (memory plus a sha256-like completion interrupt).
//             Timeout checks apply when AXIL_MST_TIMEOUT_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module tb_axil_cmd_master;
    import axil_cmd_pkg::*;

    logic        aclk;
    logic        areset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [5:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_resp;
    logic        rsp_err;
    logic [1:0]  irq;
    logic [7:0]  M_AXI_AWADDR;
    logic [2:0]  M_AXI_AWPROT;
    logic        M_AXI_AWVALID;
    logic        M_AXI_AWREADY;
    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_WVALID;
    logic        M_AXI_WREADY;
    logic [1:0]  M_AXI_BRESP;
    logic        M_AXI_BVALID;
    logic        M_AXI_BREADY;
    logic [7:0]  M_AXI_ARADDR;
    logic [2:0]  M_AXI_ARPROT;
    logic        M_AXI_ARVALID;
    logic        M_AXI_ARREADY;
    logic [31:0] M_AXI_RDATA;
    logic [1:0]  M_AXI_RRESP;
    logic        M_AXI_RVALID;
    logic        M_AXI_RREADY;

    axil_cmd_master #(
        .ADDR_WIDTH(8), .DATA_WIDTH(32), .IRQ_WIDTH(2), .TIMEOUT_CYCLES(16)
    ) dut (
        .aclk(aclk), .areset(areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_resp(rsp_resp), .rsp_err(rsp_err), .irq(irq),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
        .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // ---------------- slave model ----------------
    int          sl_aw_wait, sl_w_wait;
    logic [1:0]  sl_bresp;
    logic        sl_rblock;
    logic [1:0]  tb_irq;

    logic [31:0] mem [64];
    int          sl_aw_cnt, sl_w_cnt, sl_hash_cnt, sl_b_hs;
    logic        sl_aw_got, sl_w_got, sl_hash_done;
    logic [7:0]  sl_awaddr, sl_last_awaddr;
    logic [31:0] sl_wdata, sl_last_wdata;
    logic        sl_bvalid, sl_rvalid;
    logic [1:0]  sl_bresp_q;
    logic [31:0] sl_rdata;
    logic [7:0]  tb_wa;
    logic [31:0] tb_wd;
    logic        w_aw_hs, w_w_hs;
    logic [31:0] sl_dig [8] = '{32'hb9274db9, 32'h083e4d93, 32'hd7522ea5, 32'hfaab7dda,
                                32'he3ef84c4, 32'hee80537a, 32'hacf78890, 32'he9cdefe2};

    assign M_AXI_AWREADY = M_AXI_AWVALID && (sl_aw_cnt >= sl_aw_wait);
    assign M_AXI_WREADY  = M_AXI_WVALID && (sl_w_cnt >= sl_w_wait);
    assign M_AXI_ARREADY = M_AXI_ARVALID;
    assign M_AXI_BVALID  = sl_bvalid;
    assign M_AXI_BRESP   = sl_bresp_q;
    assign M_AXI_RVALID  = sl_rvalid;
    assign M_AXI_RDATA   = sl_rdata;
    assign M_AXI_RRESP   = 2'b00;
    assign w_aw_hs       = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_w_hs        = M_AXI_WVALID && M_AXI_WREADY;
    assign tb_wa         = w_aw_hs ? M_AXI_AWADDR : sl_awaddr;
    assign tb_wd         = w_w_hs ? M_AXI_WDATA : sl_wdata;
    assign irq           = tb_irq | {1'b0, sl_hash_done};

    // AXI4-Lite slave with memory and a delayed hash-complete interrupt
    always @(posedge aclk) begin
        if (areset) begin
            sl_aw_cnt <= 0; sl_w_cnt <= 0; sl_hash_cnt <= 0; sl_b_hs <= 0;
            sl_aw_got <= 1'b0; sl_w_got <= 1'b0; sl_hash_done <= 1'b0;
            sl_bvalid <= 1'b0; sl_rvalid <= 1'b0; sl_bresp_q <= 2'b00;
            sl_awaddr <= '0; sl_wdata <= '0; sl_rdata <= '0;
            sl_last_awaddr <= '0; sl_last_wdata <= '0;
        end else begin
            sl_aw_cnt <= (M_AXI_AWVALID && !M_AXI_AWREADY) ? sl_aw_cnt + 1 : 0;
            sl_w_cnt  <= (M_AXI_WVALID && !M_AXI_WREADY) ? sl_w_cnt + 1 : 0;
            if (sl_hash_cnt > 0) begin
                sl_hash_cnt <= sl_hash_cnt - 1;
                if (sl_hash_cnt == 1) begin
                    sl_hash_done <= 1'b1;
                    for (int i = 0; i < 8; i++) mem[8+i] <= sl_dig[i];
                end
            end
            if (w_aw_hs) begin sl_awaddr <= M_AXI_AWADDR; sl_aw_got <= 1'b1; end
            if (w_w_hs)  begin sl_wdata <= M_AXI_WDATA;   sl_w_got  <= 1'b1; end
            if ((w_aw_hs || sl_aw_got) && (w_w_hs || sl_w_got)) begin
                mem[tb_wa[7:2]] <= tb_wd;
                sl_last_awaddr  <= tb_wa;
                sl_last_wdata   <= tb_wd;
                sl_aw_got <= 1'b0; sl_w_got <= 1'b0;
                sl_bvalid <= 1'b1; sl_bresp_q <= sl_bresp;
                if (tb_wa[7:2] == 6'd0 && tb_wd[0]) begin
                    sl_hash_cnt <= 100; sl_hash_done <= 1'b0;
                end
            end
            if (sl_bvalid && M_AXI_BREADY) begin
                sl_bvalid <= 1'b0; sl_b_hs <= sl_b_hs + 1;
            end
            if (sl_rvalid && M_AXI_RREADY) sl_rvalid <= 1'b0;
            if (M_AXI_ARVALID && M_AXI_ARREADY && !sl_rblock) begin
                sl_rvalid <= 1'b1; sl_rdata <= mem[M_AXI_ARADDR[7:2]];
            end
        end
    end

    // ---------------- checking helpers ----------------
    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [5:0] addr, input logic [31:0] data);
        int w = 0;
        @(negedge aclk);
        while (!cmd_ready && w < 50) begin @(negedge aclk); w++; end
        chk("cmd_ready_seen", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data;
        @(negedge aclk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int budget, output logic [31:0] rd, output logic [1:0] rr,
                            output logic re, output int lat);
        lat = 1;
        while (!rsp_valid && lat < budget) begin @(negedge aclk); lat++; end
        chk("rsp_seen", rsp_valid, 1);
        rd = rsp_data; rr = rsp_resp; re = rsp_err;
        rsp_ready = 1'b1;
        @(negedge aclk);
        rsp_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_rsp"}, {rsp_valid, rsp_data, rsp_resp, rsp_err}, '0);
        chk({tag, "_axi_vr"}, {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY,
                               M_AXI_ARVALID, M_AXI_RREADY}, '0);
        chk({tag, "_axi_ad"}, {M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA}, '0);
    endtask

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [5:0]  addr;
        logic [31:0] data;
        logic [1:0]  bresp;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t        vecs [6];
    logic [31:0] rd;
    logic [1:0]  rr;
    logic        re;
    int          lat, bh0, seen;
    logic [31:0] msg [16];
    logic [31:0] exp_be [8] = '{32'hb94d27b9, 32'h934d3e08, 32'ha52e52d7, 32'hda7dabfa,
                                32'hc484efe3, 32'h7a5380ee, 32'h9088f7ac, 32'he2efcde9};
    logic [31:0] w_be;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{"wr_ctrl",  OP_WRITE,    6'h00, 32'h3,        2'b00, 32'h0,        2'b00, 1'b0, 3};
        vecs[1] = '{"wr_slverr",OP_WRITE,    6'h05, 32'hdeadbeef, 2'b10, 32'h0,        2'b10, 1'b0, 3};
        vecs[2] = '{"rd_05",    OP_READ,     6'h05, 32'h0,        2'b00, 32'hdeadbeef, 2'b00, 1'b0, 3};
        vecs[3] = '{"rd_00",    OP_READ,     6'h00, 32'h0,        2'b00, 32'h3,        2'b00, 1'b0, 3};
        vecs[4] = '{"rsvd_op",  OP_RSVD,     6'h01, 32'h0,        2'b00, 32'h0,        2'b00, 1'b1, 1};
        vecs[5] = '{"irq_mask0",OP_WAIT_IRQ, 6'h00, 32'h0,        2'b00, 32'h0,        2'b00, 1'b1, 2};
        msg = '{32'h6c6c6568, 32'h6f77206f, 32'h80646c72, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h58000000};

        sl_aw_wait = 0; sl_w_wait = 0; sl_bresp = 2'b00; sl_rblock = 1'b0; tb_irq = 2'b00;
        cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0; cmd_data = '0; rsp_ready = 1'b0;
        areset = 1'b1;
        repeat (3) @(negedge aclk);
        check_reset_outputs("reset");
        areset = 1'b0;

        // Table-driven single commands against a zero-wait slave
        for (int i = 0; i < 6; i++) begin
            sl_bresp = vecs[i].bresp;
            send_cmd(vecs[i].op, vecs[i].addr, vecs[i].data);
            wait_rsp(40, rd, rr, re, lat);
            chk({vecs[i].name, "_data"}, rd, vecs[i].exp_data);
            chk({vecs[i].name, "_resp"}, rr, vecs[i].exp_resp);
            chk({vecs[i].name, "_err"},  re, vecs[i].exp_err);
            chk({vecs[i].name, "_lat"},  lat, vecs[i].exp_lat);
            if (vecs[i].op == OP_WRITE) begin
                chk({vecs[i].name, "_awaddr"}, sl_last_awaddr, {vecs[i].addr, 2'b00});
                chk({vecs[i].name, "_wdata"},  sl_last_wdata, vecs[i].data);
            end
        end
        sl_bresp = 2'b00;

        // Full SHA256 flow: start, message, wait for completion, read digest
        send_cmd(OP_WRITE, 6'(SHA_CTRL_WORD), 32'h3);
        wait_rsp(40, rd, rr, re, lat);
        for (int i = 0; i < 16; i++) begin
            send_cmd(OP_WRITE, 6'(SHA_MSG_WORD + i), msg[i]);
            wait_rsp(40, rd, rr, re, lat);
        end
        chk("sha_msg_first", mem[16], 32'h6c6c6568);
        chk("sha_msg_last",  mem[31], 32'h58000000);
        send_cmd(OP_WAIT_IRQ, 6'h00, 32'h1);
        wait_rsp(300, rd, rr, re, lat);
        chk("sha_irq_data", rd, 32'h1);
        chk("sha_irq_err",  re, 1'b0);
        for (int i = 0; i < 8; i++) begin
            send_cmd(OP_READ, 6'(SHA_HASH_WORD + i), 32'h0);
            wait_rsp(40, rd, rr, re, lat);
            w_be = exp_be[i];
            chk("sha_digest", rd, {w_be[7:0], w_be[15:8], w_be[23:16], w_be[31:24]});
        end

        // AWREADY two cycles before WREADY
        sl_w_wait = 2;
        bh0 = sl_b_hs;
        send_cmd(OP_WRITE, 6'h11, 32'h12345678);
        chk("split_c1_valids", {M_AXI_AWVALID, M_AXI_WVALID}, 2'b11);
        @(negedge aclk);
        chk("split_c2_valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}, 3'b010);
        wait_rsp(40, rd, rr, re, lat);
        chk("split_lat",  lat + 1, 5);
        chk("split_resp", {rr, re}, 3'b000);
        chk("split_mem",  mem[6'h11], 32'h12345678);
        seen = 0;
        repeat (3) begin @(negedge aclk); if (rsp_valid) seen++; end
        chk("split_b_count", sl_b_hs - bh0, 1);
        chk("split_single_rsp", seen, 0);
        sl_w_wait = 0;

        // Slave never returns read data
        sl_rblock = 1'b1;
`ifdef AXIL_MST_TIMEOUT_EN
        send_cmd(OP_READ, 6'h00, 32'h0);
        wait_rsp(40, rd, rr, re, lat);
        chk("tmo_err",  re, 1'b1);
        chk("tmo_resp", rr, 2'b10);
        chk("tmo_data", rd, 32'h0);
        chk("tmo_lat",  lat, 18);
        sl_rblock = 1'b0;
        send_cmd(OP_READ, 6'h00, 32'h0);
        wait_rsp(40, rd, rr, re, lat);
        chk("after_tmo_data", rd, 32'h3);
        chk("after_tmo_err",  re, 1'b0);
        sl_rblock = 1'b1;
        send_cmd(OP_READ, 6'h05, 32'h0);
        repeat (3) @(negedge aclk);
`else
        send_cmd(OP_READ, 6'h05, 32'h0);
        seen = 0;
        repeat (30) begin @(negedge aclk); if (rsp_valid) seen++; end
        chk("no_tmo_wait", seen, 0);
`endif
        chk("in_rd_r", M_AXI_RREADY, 1'b1);

        // Reset pulse during RD_R
        areset = 1'b1;
        @(negedge aclk);
        areset = 1'b0;
        check_reset_outputs("midreset");
        sl_rblock = 1'b0;

        // Response held while the consumer stalls
        send_cmd(OP_READ, 6'h05, 32'h0);
        lat = 1;
        while (!rsp_valid && lat < 40) begin @(negedge aclk); lat++; end
        chk("hold_lat", lat, 3);
        seen = 0;
        repeat (5) begin
            @(negedge aclk);
            if (rsp_valid && rsp_data == 32'hdeadbeef && rsp_err == 1'b0) seen++;
        end
        chk("hold_stable", seen, 5);
        rsp_ready = 1'b1;
        @(negedge aclk);
        rsp_ready = 1'b0;
        chk("hold_released", {rsp_valid, cmd_ready}, 2'b01);

        // WAIT_IRQ stalls until the masked line rises
        tb_irq = 2'b01;
        send_cmd(OP_WAIT_IRQ, 6'h00, 32'h2);
        seen = 0;
        repeat (6) begin @(negedge aclk); if (rsp_valid) seen++; end
        chk("irq_stall", seen, 0);
        tb_irq = 2'b11;
        @(negedge aclk);
        wait_rsp(10, rd, rr, re, lat);
        chk("irq_data", rd, 32'h3);
        chk("irq_resp_err", {rr, re}, 3'b000);
        tb_irq = 2'b00;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
